// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID record.
package if_fetch_stage_pkg;

  localparam int unsigned PC_W = 16;
  localparam logic [PC_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  // IF/ID pipeline record, shared with the decode stage
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] instr;
    logic            valid;
  } ifid_rec_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction memory port and IF/ID outputs.
interface if_fetch_stage_if #(
  parameter int unsigned PC_W = if_fetch_stage_pkg::PC_W
);

  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [PC_W-1:0] imem_rdata;
  logic            imem_ready;
  logic [PC_W-1:0] ifid_pc;
  logic [PC_W-1:0] ifid_instr;
  logic            ifid_valid;

  modport master (
    input  stall, branch_taken, branch_target, imem_rdata, imem_ready,
    output imem_req, imem_addr, ifid_pc, ifid_instr, ifid_valid
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_rdata, imem_ready,
    input  imem_req, imem_addr, ifid_pc, ifid_instr, ifid_valid
  );

endinterface

// File: rtl/if_fetch_stage_fetch_hold_buf.sv
// One-entry buffer parking a fetched {pc, instr} while IF/ID is stalled.
module fetch_hold_buf #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         drain,
  input  logic         clear,
  input  logic [W-1:0] load_pc,
  input  logic [W-1:0] load_instr,
  output logic [W-1:0] held_pc,
  output logic [W-1:0] held_instr,
  output logic         full
);

  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] instr_q, instr_d;
  logic         full_q, full_d;

  // clear wins over load; drain only empties
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    full_d  = full_q;
    if (clear || drain) begin
      full_d = 1'b0;
    end else if (load) begin
      pc_d    = load_pc;
      instr_d = load_instr;
      full_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= '0;
      full_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      full_q  <= full_d;
    end
  end

  assign held_pc    = pc_q;
  assign held_instr = instr_q;
  assign full       = full_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, drives imem, and loads the IF/ID register,
// parking a completed fetch in a hold buffer across hazard stalls.
module if_fetch_stage #(
  parameter int unsigned    PC_W      = if_fetch_stage_pkg::PC_W,
  parameter int unsigned    PC_INC    = 1,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [PC_W-1:0] NOP_INSTR = PC_W'(if_fetch_stage_pkg::NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst,
  if_fetch_stage_if.master  bus
);

  import if_fetch_stage_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
  logic [PC_W-1:0] ifid_instr_q, ifid_instr_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [PC_W-1:0] pc_inc;
  logic            hb_load, hb_drain, hb_clear, hb_full;
  logic [PC_W-1:0] hb_pc, hb_instr;

  assign pc_inc = pc_q + PC_W'(PC_INC);

  fetch_hold_buf #(.W(PC_W)) u_hold_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (hb_load),
    .drain      (hb_drain),
    .clear      (hb_clear),
    .load_pc    (pc_inc),
    .load_instr (bus.imem_rdata),
    .held_pc    (hb_pc),
    .held_instr (hb_instr),
    .full       (hb_full)
  );

  // Next state, next PC and IF/ID update; redirect outranks stall and memory
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    hb_load      = 1'b0;
    hb_drain     = 1'b0;
    hb_clear     = 1'b0;
    if (bus.branch_taken) begin
      pc_d         = bus.branch_target;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      hb_clear     = 1'b1;
      state_d      = ST_FETCH;
    end else begin
      unique case (state_q)
        ST_BOOT: state_d = ST_FETCH;
        ST_FETCH: begin
          if (bus.imem_ready) begin
            pc_d = pc_inc;
            if (bus.stall) begin
              hb_load = 1'b1;
              state_d = ST_HOLD;
            end else begin
              ifid_pc_d    = pc_inc;
              ifid_instr_d = bus.imem_rdata;
              ifid_valid_d = 1'b1;
            end
          end else if (!bus.stall) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
          end
        end
        ST_HOLD: begin
          if (!bus.stall) begin
            ifid_pc_d    = hb_pc;
            ifid_instr_d = hb_instr;
            ifid_valid_d = hb_full;
            hb_drain     = 1'b1;
            state_d      = ST_FETCH;
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign bus.imem_req   = (state_q == ST_FETCH);
  assign bus.imem_addr  = pc_q;
  assign bus.ifid_pc    = ifid_pc_q;
  assign bus.ifid_instr = ifid_instr_q;
  assign bus.ifid_valid = ifid_valid_q;

endmodule
